// File: rtl/issue_hazard_pkg.sv
// Shared types and helpers for the dual-lane ID-stage issue hazard unit.
package issue_hazard_pkg;

    localparam int unsigned REG_W = 5;

    typedef enum logic {
        LANE1 = 1'b0,
        LANE2 = 1'b1
    } lane_e;

    typedef enum logic [1:0] {
        CLS_ALU,
        CLS_LOAD,
        CLS_DIV
    } iclass_e;

    typedef struct packed {
        logic             valid;
        logic [REG_W-1:0] rs1;
        logic [REG_W-1:0] rs2;
        logic [REG_W-1:0] rd;
        logic             rs1_use;
        logic             rs2_use;
        logic             we;
        iclass_e          cls;
    } lane_t;

    // x0 is hard-wired, so it never carries a dependency.
    function automatic logic regmatch(input logic [REG_W-1:0] idx, input logic used,
                                      input logic [REG_W-1:0] rd);
        return used && (idx != '0) && (idx == rd);
    endfunction

    function automatic logic src_hit(input lane_t l, input logic [REG_W-1:0] rd);
        return regmatch(l.rs1, l.rs1_use, rd) || regmatch(l.rs2, l.rs2_use, rd);
    endfunction

endpackage

// File: rtl/issue_hazard_div_occupancy.sv
// Divider occupancy tracker: down-counter from launch to result plus the destination register.
module div_occupancy_t
    import issue_hazard_pkg::*;
#(
    parameter int unsigned DIV_CYCLES = 8,
    parameter int unsigned CNT_W      = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             start,
    input  logic             kill,
    input  logic [REG_W-1:0] start_rd,
    output logic             busy,
    output logic [REG_W-1:0] div_rd
);

    logic [CNT_W-1:0] cnt;

    // Kill wins over a same-cycle launch so a redirect never leaves residual occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            div_rd <= '0;
        end else if (en) begin
            if (kill) begin
                cnt <= '0;
            end else if (start) begin
                cnt    <= CNT_W'(DIV_CYCLES - 1);
                div_rd <= start_rd;
            end else if (cnt != '0) begin
                cnt <= cnt - 1'b1;
            end
        end
    end

    assign busy = (cnt != '0);

endmodule

// File: rtl/issue_hazard_t.sv
// Dual-lane ID-stage hazard unit: per-lane stalls, IF hold, split-pair issued mask,
// one-cycle load scoreboard and divider occupancy.
module issue_hazard_t
    import issue_hazard_pkg::*;
#(
    parameter int unsigned DIV_CYCLES = 8,
    parameter int unsigned CNT_W      = 5
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             ACT,
    input  logic             id1_valid,
    input  logic             id2_valid,
    input  logic [REG_W-1:0] id1_rs1,
    input  logic [REG_W-1:0] id1_rs2,
    input  logic [REG_W-1:0] id1_rd,
    input  logic [REG_W-1:0] id2_rs1,
    input  logic [REG_W-1:0] id2_rs2,
    input  logic [REG_W-1:0] id2_rd,
    input  logic             id1_rs1_use,
    input  logic             id1_rs2_use,
    input  logic             id2_rs1_use,
    input  logic             id2_rs2_use,
    input  logic             id1_we,
    input  logic             id2_we,
    input  logic             id1_load,
    input  logic             id2_load,
    input  logic             id1_div,
    input  logic             id2_div,
    input  logic             id_lane2_first,
    input  logic             s_ex1_clear_Q,
    input  logic             s_ex2_clear_Q,
    input  logic             s_flush_Q,
    output logic             s_id1_stall_D,
    output logic             s_id2_stall_D,
    output logic             s_id2_older_D,
    output logic             s_if_stall_D,
    output logic             div_start,
    output logic             div_busy
);

    lane_t            ln [2];
    logic [1:0]       active;
    logic [1:0]       own_hz;
    logic [1:0]       stall;
    logic [1:0]       go;
    logic [1:0]       ex_clear;
    logic [1:0]       issued;
    logic [1:0]       sb_valid;
    logic [REG_W-1:0] sb_rd [2];
    logic [REG_W-1:0] div_rd;
    logic [REG_W-1:0] start_rd;
    logic             en;
    logic             pair_hz;
    lane_e            older;
    lane_e            younger;

    assign en       = ACT & RST;
    assign ex_clear = {s_ex2_clear_Q, s_ex1_clear_Q};
    assign older    = id_lane2_first ? LANE2 : LANE1;
    assign younger  = id_lane2_first ? LANE1 : LANE2;

    always_comb begin
        ln[0].valid   = id1_valid;
        ln[0].rs1     = id1_rs1;
        ln[0].rs2     = id1_rs2;
        ln[0].rd      = id1_rd;
        ln[0].rs1_use = id1_rs1_use;
        ln[0].rs2_use = id1_rs2_use;
        ln[0].we      = id1_we;
        ln[0].cls     = id1_div ? CLS_DIV : (id1_load ? CLS_LOAD : CLS_ALU);
        ln[1].valid   = id2_valid;
        ln[1].rs1     = id2_rs1;
        ln[1].rs2     = id2_rs2;
        ln[1].rd      = id2_rd;
        ln[1].rs1_use = id2_rs1_use;
        ln[1].rs2_use = id2_rs2_use;
        ln[1].we      = id2_we;
        ln[1].cls     = id2_div ? CLS_DIV : (id2_load ? CLS_LOAD : CLS_ALU);
    end

    // Scoreboard entries are masked in the same cycle their EX lane is cleared or flushed.
    always_comb begin
        for (int unsigned n = 0; n < 2; n++) begin
            active[n] = ln[n].valid & ~issued[n];
            own_hz[n] = 1'b0;
            for (int unsigned e = 0; e < 2; e++) begin
                if (sb_valid[e] && !ex_clear[e] && !s_flush_Q && src_hit(ln[n], sb_rd[e]))
                    own_hz[n] = 1'b1;
            end
            if (div_busy && (src_hit(ln[n], div_rd) || regmatch(ln[n].rd, ln[n].we, div_rd) ||
                             ln[n].cls == CLS_DIV))
                own_hz[n] = 1'b1;
        end
        pair_hz = active[older] &
                  (own_hz[older] |
                   (ln[older].we & src_hit(ln[younger], ln[older].rd)) |
                   (ln[older].cls == CLS_DIV && ln[younger].cls == CLS_DIV));
        stall          = '0;
        stall[older]   = en & active[older] & own_hz[older];
        stall[younger] = en & active[younger] & (own_hz[younger] | pair_hz);
        go             = {2{en}} & active & ~stall;
    end

    assign div_start = (go[0] & (ln[0].cls == CLS_DIV)) | (go[1] & (ln[1].cls == CLS_DIV));
    assign start_rd  = (go[1] && ln[1].cls == CLS_DIV) ? (ln[1].we ? ln[1].rd : '0)
                                                        : (ln[0].we ? ln[0].rd : '0);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            issued   <= '0;
            sb_valid <= '0;
            sb_rd[0] <= '0;
            sb_rd[1] <= '0;
        end else if (ACT) begin
            issued <= (s_flush_Q || !s_if_stall_D) ? '0 : (issued | go);
            for (int unsigned n = 0; n < 2; n++) begin
                sb_valid[n] <= ~s_flush_Q & go[n] & (ln[n].cls == CLS_LOAD) & ln[n].we &
                               (ln[n].rd != '0);
                sb_rd[n]    <= ln[n].rd;
            end
        end
    end

    div_occupancy_t #(
        .DIV_CYCLES(DIV_CYCLES),
        .CNT_W     (CNT_W)
    ) u_div (
        .clk     (CLK),
        .rst_n   (RST),
        .en      (ACT),
        .start   (div_start),
        .kill    (s_flush_Q),
        .start_rd(start_rd),
        .busy    (div_busy),
        .div_rd  (div_rd)
    );

    assign s_id1_stall_D = stall[0];
    assign s_id2_stall_D = stall[1];
    assign s_if_stall_D  = |stall;
    assign s_id2_older_D = RST & id_lane2_first;

endmodule

// File: tb/tb_issue_hazard_t.sv
// Bench for issue_hazard_t: vector table, directed multi-cycle sequences, random vs. reference model.
module tb_issue_hazard_t;

    localparam int DIVC = 8;

    logic       CLK = 1'b0, RST = 1'b0, ACT = 1'b0;
    logic       id1_valid, id2_valid, id1_rs1_use, id1_rs2_use, id2_rs1_use, id2_rs2_use;
    logic [4:0] id1_rs1, id1_rs2, id1_rd, id2_rs1, id2_rs2, id2_rd;
    logic       id1_we, id2_we, id1_load, id2_load, id1_div, id2_div, id_lane2_first;
    logic       s_ex1_clear_Q = 1'b0, s_ex2_clear_Q = 1'b0, s_flush_Q = 1'b0;
    logic       s_id1_stall_D, s_id2_stall_D, s_id2_older_D, s_if_stall_D, div_start, div_busy;

    issue_hazard_t #(.DIV_CYCLES(DIVC), .CNT_W(5)) dut (
        .CLK(CLK), .RST(RST), .ACT(ACT),
        .id1_valid(id1_valid), .id2_valid(id2_valid),
        .id1_rs1(id1_rs1), .id1_rs2(id1_rs2), .id1_rd(id1_rd),
        .id2_rs1(id2_rs1), .id2_rs2(id2_rs2), .id2_rd(id2_rd),
        .id1_rs1_use(id1_rs1_use), .id1_rs2_use(id1_rs2_use),
        .id2_rs1_use(id2_rs1_use), .id2_rs2_use(id2_rs2_use),
        .id1_we(id1_we), .id2_we(id2_we), .id1_load(id1_load), .id2_load(id2_load),
        .id1_div(id1_div), .id2_div(id2_div), .id_lane2_first(id_lane2_first),
        .s_ex1_clear_Q(s_ex1_clear_Q), .s_ex2_clear_Q(s_ex2_clear_Q), .s_flush_Q(s_flush_Q),
        .s_id1_stall_D(s_id1_stall_D), .s_id2_stall_D(s_id2_stall_D),
        .s_id2_older_D(s_id2_older_D), .s_if_stall_D(s_if_stall_D),
        .div_start(div_start), .div_busy(div_busy)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic v; logic [4:0] rs1; logic u1; logic [4:0] rs2; logic u2;
        logic [4:0] rd; logic we; logic ld; logic dv;
    } ins_t;

    typedef struct {
        ins_t l1; ins_t l2; logic l2f; logic act;
        logic e1; logic e2; logic est;
    } vec_t;

    int n_pass = 0, n_chk = 0;

    function automatic ins_t mk(input logic v, input int rs1, input logic u1, input int rs2,
                                input logic u2, input int rd, input logic we, input logic ld,
                                input logic dv);
        ins_t x;
        x.v = v; x.rs1 = 5'(rs1); x.u1 = u1; x.rs2 = 5'(rs2); x.u2 = u2;
        x.rd = 5'(rd); x.we = we; x.ld = ld; x.dv = dv;
        return x;
    endfunction

    task automatic apply(input ins_t a, input ins_t b, input logic l2f);
        id1_valid = a.v; id1_rs1 = a.rs1; id1_rs1_use = a.u1; id1_rs2 = a.rs2; id1_rs2_use = a.u2;
        id1_rd = a.rd; id1_we = a.we; id1_load = a.ld; id1_div = a.dv;
        id2_valid = b.v; id2_rs1 = b.rs1; id2_rs1_use = b.u1; id2_rs2 = b.rs2; id2_rs2_use = b.u2;
        id2_rd = b.rd; id2_we = b.we; id2_load = b.ld; id2_div = b.dv;
        id_lane2_first = l2f;
    endtask

    task automatic chk_out(input string nm, input logic e1, input logic e2, input logic est,
                           input logic eb);
        logic [4:0] got, exp;
        got = {s_id1_stall_D, s_id2_stall_D, s_if_stall_D, div_start, div_busy};
        exp = {e1, e2, e1 | e2, est, eb};
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s {st1,st2,if,start,busy}: got %b required %b at %0t", nm, got, exp, $time);
    endtask

    task automatic chk_bit(input string nm, input logic got, input logic exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %b required %b at %0t", nm, got, exp, $time);
    endtask

    task automatic tick();
        @(posedge CLK); #1;
    endtask

    // ---------------- reference model ----------------
    int   m_left, m_dst;
    int   m_ld [2];
    bit   m_done [2];
    ins_t cur [2];
    bit   c_l2f, c_act, c_fl;
    bit   c_clr [2];

    function automatic bit reads(input ins_t x, input int r);
        return r != 0 && ((x.u1 && int'(x.rs1) == r) || (x.u2 && int'(x.rs2) == r));
    endfunction

    task automatic model_reset();
        m_left = 0; m_dst = 0;
        for (int n = 0; n < 2; n++) begin m_ld[n] = 0; m_done[n] = 0; end
    endtask

    task automatic model_predict(output bit [1:0] st, output bit est, output bit eb);
        bit [1:0] actv, own;
        int o, y;
        for (int n = 0; n < 2; n++) begin
            actv[n] = cur[n].v && !m_done[n];
            own[n]  = 0;
            for (int e = 0; e < 2; e++)
                if (m_ld[e] != 0 && !c_clr[e] && !c_fl && reads(cur[n], m_ld[e])) own[n] = 1;
            if (m_left > 0 && (cur[n].dv || reads(cur[n], m_dst) ||
                               (cur[n].we && cur[n].rd != 0 && int'(cur[n].rd) == m_dst)))
                own[n] = 1;
        end
        o = c_l2f ? 1 : 0;
        y = 1 - o;
        st    = '0;
        st[o] = c_act && actv[o] && own[o];
        st[y] = c_act && actv[y] &&
                (own[y] || (actv[o] && (own[o] || (cur[o].we && reads(cur[y], int'(cur[o].rd))) ||
                                        (cur[o].dv && cur[y].dv))));
        est = 0;
        for (int n = 0; n < 2; n++)
            if (c_act && actv[n] && !st[n] && cur[n].dv) est = 1;
        eb = m_left > 0;
    endtask

    task automatic model_commit(input bit [1:0] st);
        bit [1:0] iss;
        bit started;
        int sdst;
        if (!c_act) return;
        started = 0; sdst = 0;
        for (int n = 0; n < 2; n++) begin
            iss[n] = cur[n].v && !m_done[n] && !st[n];
            if (iss[n] && cur[n].dv) begin
                started = 1;
                sdst = cur[n].we ? int'(cur[n].rd) : 0;
            end
        end
        if (c_fl) m_left = 0;
        else if (started) begin m_left = DIVC - 1; m_dst = sdst; end
        else if (m_left > 0) m_left--;
        for (int n = 0; n < 2; n++)
            m_ld[n] = (!c_fl && iss[n] && cur[n].ld && cur[n].we && cur[n].rd != 0) ? int'(cur[n].rd) : 0;
        for (int n = 0; n < 2; n++)
            m_done[n] = (c_fl || st == 2'b00) ? 1'b0 : (m_done[n] || iss[n]);
    endtask

    function automatic ins_t rnd_ins();
        ins_t x;
        int k;
        k = int'($urandom_range(0, 99));
        x.v = ($urandom_range(0, 99) < 85);
        x.rs1 = 5'($urandom_range(0, 7)); x.u1 = 1'($urandom_range(0, 1));
        x.rs2 = 5'($urandom_range(0, 7)); x.u2 = 1'($urandom_range(0, 1));
        x.rd = 5'($urandom_range(0, 7));  x.we = ($urandom_range(0, 9) < 8);
        x.ld = (k < 25); x.dv = (k >= 25 && k < 33);
        return x;
    endfunction

    // ---------------- stimulus ----------------
    ins_t nop, add5, sub65, w3, r3, w0, r0, r5nu, div9, div10, r9, r5b, lw7, r7, lw4, r4, div11, inv5;
    vec_t tbl [12];

    task automatic do_reset();
        RST = 1'b0; ACT = 1'b0;
        s_ex1_clear_Q = 1'b0; s_ex2_clear_Q = 1'b0; s_flush_Q = 1'b0;
        apply(nop, nop, 1'b0);
        @(posedge CLK); #1;
        RST = 1'b1; ACT = 1'b1;
        model_reset();
    endtask

    initial begin
        bit [1:0] est_st;
        bit       e_start, e_busy, hold;

        nop   = '0;
        add5  = mk(1, 1, 1, 2, 1, 5, 1, 0, 0);
        sub65 = mk(1, 5, 1, 1, 1, 6, 1, 0, 0);
        w3    = mk(1, 1, 1, 2, 1, 3, 1, 0, 0);
        r3    = mk(1, 3, 1, 0, 0, 8, 1, 0, 0);
        w0    = mk(1, 1, 1, 2, 1, 0, 1, 0, 0);
        r0    = mk(1, 0, 1, 0, 1, 8, 1, 0, 0);
        r5nu  = mk(1, 5, 0, 5, 0, 8, 1, 0, 0);
        div9  = mk(1, 1, 1, 2, 1, 9, 1, 0, 1);
        div10 = mk(1, 3, 1, 4, 1, 10, 1, 0, 1);
        r9    = mk(1, 9, 1, 0, 0, 10, 1, 0, 0);
        r5b   = mk(1, 1, 1, 5, 1, 8, 1, 0, 0);
        lw7   = mk(1, 1, 1, 0, 0, 7, 1, 1, 0);
        r7    = mk(1, 7, 1, 0, 0, 8, 1, 0, 0);
        lw4   = mk(1, 1, 1, 0, 0, 4, 1, 1, 0);
        r4    = mk(1, 4, 1, 0, 0, 5, 1, 0, 0);
        div11 = mk(1, 1, 1, 2, 1, 11, 1, 0, 1);
        inv5  = mk(0, 1, 1, 2, 1, 5, 1, 0, 0);

        tbl[0]  = '{add5, sub65, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[1]  = '{add5, sub65, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[2]  = '{r3,   w3,    1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[3]  = '{w0,   r0,    1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[4]  = '{add5, r5nu,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[5]  = '{div9, div10, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        tbl[6]  = '{div9, div10, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        tbl[7]  = '{inv5, sub65, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[8]  = '{add5, sub65, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[9]  = '{div9, r9,    1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        tbl[10] = '{add5, add5,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[11] = '{add5, r5b,   1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

        // Reset asserted: everything low even with a hazardous pair presented.
        ACT = 1'b1;
        apply(div9, r9, 1'b1);
        #2;
        chk_out("reset", 0, 0, 0, 0);
        chk_bit("reset older", s_id2_older_D, 1'b0);

        foreach (tbl[i]) begin
            do_reset();
            ACT = tbl[i].act;
            apply(tbl[i].l1, tbl[i].l2, tbl[i].l2f);
            @(negedge CLK);
            chk_out($sformatf("vec%0d", i), tbl[i].e1, tbl[i].e2, tbl[i].est, 1'b0);
            chk_bit($sformatf("vec%0d older", i), s_id2_older_D, tbl[i].l2f);
        end

        // Split pair: younger issues alone next cycle, then the mask is clear again.
        do_reset();
        apply(add5, sub65, 1'b0);
        @(negedge CLK); chk_out("split c0", 0, 1, 0, 0);
        tick(); @(negedge CLK); chk_out("split c1", 0, 0, 0, 0);
        tick(); @(negedge CLK); chk_out("split mask cleared", 0, 1, 0, 0);

        // Load-use, plain and with the load's EX lane cleared.
        do_reset();
        apply(lw7, nop, 1'b0);
        @(negedge CLK); chk_out("lu c0", 0, 0, 0, 0);
        tick(); apply(r7, w3, 1'b0);
        @(negedge CLK); chk_out("lu c1", 1, 1, 0, 0);
        tick(); @(negedge CLK); chk_out("lu c2", 0, 0, 0, 0);
        do_reset();
        apply(lw7, nop, 1'b0);
        tick(); apply(r7, w3, 1'b0); s_ex1_clear_Q = 1'b1;
        @(negedge CLK); chk_out("lu cleared", 0, 0, 0, 0);
        tick(); s_ex1_clear_Q = 1'b0;

        // Divider RAW: independent older add never stalls, reader stalls all 7 busy cycles.
        do_reset();
        apply(div9, nop, 1'b0);
        @(negedge CLK); chk_out("div launch", 0, 0, 1, 0);
        tick(); apply(w3, r9, 1'b0);
        for (int k = 1; k < DIVC; k++) begin
            @(negedge CLK); chk_out($sformatf("div raw c%0d", k), 0, 1, 0, 1);
            tick();
        end
        @(negedge CLK); chk_out("div raw done", 0, 0, 0, 0);

        // Divider structural.
        do_reset();
        apply(div9, nop, 1'b0);
        tick(); apply(div11, nop, 1'b0);
        for (int k = 1; k < DIVC; k++) begin
            @(negedge CLK); chk_out($sformatf("div struct c%0d", k), 1, 0, 0, 1);
            tick();
        end
        @(negedge CLK); chk_out("div struct done", 0, 0, 1, 0);

        // Lane 2 older load, lane 1 younger reader.
        do_reset();
        apply(nop, lw4, 1'b1);
        @(negedge CLK); chk_out("l2f c0", 0, 0, 0, 0);
        tick(); apply(r4, nop, 1'b1);
        @(negedge CLK); chk_out("l2f c1", 1, 0, 0, 0);
        chk_bit("l2f older", s_id2_older_D, 1'b1);
        tick(); @(negedge CLK); chk_out("l2f c2", 0, 0, 0, 0);

        // Flush two cycles after a divide launch.
        do_reset();
        apply(div9, nop, 1'b0);
        tick(); apply(r9, nop, 1'b0);
        @(negedge CLK); chk_out("flush c1", 1, 0, 0, 1);
        tick(); s_flush_Q = 1'b1;
        @(negedge CLK); chk_out("flush c2", 1, 0, 0, 1);
        tick(); s_flush_Q = 1'b0;
        @(negedge CLK); chk_out("flush c3", 0, 0, 0, 0);

        // Reset mid-divide with the counter at 5.
        do_reset();
        apply(div9, nop, 1'b0);
        tick(); apply(w3, r9, 1'b0);
        for (int k = 1; k <= 3; k++) begin
            @(negedge CLK); chk_out($sformatf("mid c%0d", k), 0, 1, 0, 1);
            if (k < 3) tick();
        end
        RST = 1'b0; #1;
        chk_out("mid rst", 0, 0, 0, 0);
        tick(); RST = 1'b1;
        apply(add5, sub65, 1'b0);
        @(negedge CLK); chk_out("mid post mask", 0, 1, 0, 0);
        do_reset();
        apply(w0, r0, 1'b0);
        @(negedge CLK); chk_out("mid x0", 0, 0, 0, 0);

        // Random traffic against the reference model.
        do_reset();
        hold = 0;
        for (int c = 0; c < 400; c++) begin
            if (!hold) begin
                cur[0] = rnd_ins(); cur[1] = rnd_ins();
                c_l2f = 1'($urandom_range(0, 1));
            end
            c_act = ($urandom_range(0, 99) < 90);
            c_clr[0] = ($urandom_range(0, 99) < 10);
            c_clr[1] = ($urandom_range(0, 99) < 10);
            c_fl = ($urandom_range(0, 99) < 5);
            ACT = c_act; s_ex1_clear_Q = c_clr[0]; s_ex2_clear_Q = c_clr[1]; s_flush_Q = c_fl;
            apply(cur[0], cur[1], c_l2f);
            @(negedge CLK);
            model_predict(est_st, e_start, e_busy);
            chk_out($sformatf("rand c%0d", c), est_st[0], est_st[1], e_start, e_busy);
            chk_bit($sformatf("rand older c%0d", c), s_id2_older_D, c_l2f);
            model_commit(est_st);
            hold = c_act && (est_st != 2'b00);
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/issue_hazard_t.md
Name: issue_hazard_t

Overview:
- Dual-lane issue hazard unit in the ID stage, directly upstream of flush_control_t.
- Produces the per-lane ID stall strobes, the lane-age flag and the IF hold strobe; flush_control_t turns these into EX/ME/WB clears.
- Detects three hazards: intra-pair RAW, load-use against loads one cycle ahead in EX, and occupancy/RAW/WAW on the multi-cycle divider.
- Holds an issued-lane mask so a split pair is never issued twice.

Parameters:
- DIV_CYCLES, 8, divider occupancy in cycles from issue to result (legal range 2..31).
- CNT_W, 5, width of the divider down-counter; must satisfy 2^CNT_W > DIV_CYCLES.

Ports:
- CLK  in  1  core clock
- RST  in  1  asynchronous active-low reset (asserted at 0)
- ACT  in  1  stage activity enable; when 0, state holds and all stall outputs are 0
- id1_valid, id2_valid  in  1 each  lane holds a decoded instruction
- id1_rs1, id1_rs2, id1_rd, id2_rs1, id2_rs2, id2_rd  in  5 each  register indices
- id1_rs1_use, id1_rs2_use, id2_rs1_use, id2_rs2_use  in  1 each  source operand actually read
- id1_we, id2_we  in  1 each  lane writes rd
- id1_load, id2_load, id1_div, id2_div  in  1 each  instruction class
- id_lane2_first  in  1  fetch order: lane 2 is the older instruction
- s_ex1_clear_Q, s_ex2_clear_Q  in  1 each  EX lane cleared this cycle (from flush_control_t)
- s_flush_Q  in  1  redirect (ME/EX pcsrc): kills the divider and the scoreboard
- s_id1_stall_D, s_id2_stall_D  out  1 each  lane held in ID this cycle
- s_id2_older_D  out  1  equals id_lane2_first (combinational)
- s_if_stall_D  out  1  hold fetch/ID pair
- div_start  out  1  divider launch pulse
- div_busy  out  1  divider counter non-zero

Behaviour:
- Reset (RST=0, asynchronous): counter=0, div_rd=0, scoreboard valid bits=0, issued mask=00. All outputs 0 while reset is asserted.
- Lane active: `idN_valid & ~issued[N]`.
- Hazard on a source register: the source counts only when its `_use` bit is 1 and its index is not 0.
- Stall conditions for an active lane. A lane stalls if any of the following holds:
  - Load-use: a source matches the rd of a valid scoreboard entry.
  - Divider RAW/WAW: div_busy=1 and (a source == div_rd, or (we=1 and rd == div_rd)).
  - Divider structural: the lane is a div and div_busy=1.
  - Intra-pair RAW: the lane is the younger, the older lane is active with we=1 and rd≠0, and one of the younger lane's sources == older rd.
  - Pair rule: the lane is the younger, the older lane is active and stalls, so the younger stalls too.
  - Dual div: both lanes are div, so the younger stalls.
- Younger never issues ahead of the older.
- s_if_stall_D = s_id1_stall_D | s_id2_stall_D.
- Issued mask:
  - A lane that is active and not stalled while the other lane stalls sets issued[N] at the next edge.
  - The mask clears to 00 on any cycle where s_if_stall_D=0, and on s_flush_Q.
- Scoreboard: one entry per lane, life of exactly one cycle.
  - Entry N is loaded next cycle with {valid = active & load & we & rd≠0 & ~stall, rd}.
  - Entry N is invalidated if s_ex(N)_clear_Q is asserted that cycle or if s_flush_Q=1.
- Divider:
  - div_start = an active, non-stalled div lane, with ACT=1.
  - On div_start: counter loads DIV_CYCLES-1 and div_rd loads that lane's rd (0 if we=0).
  - Otherwise, while the counter is non-zero, it decrements by 1 each cycle.
  - s_flush_Q forces the counter to 0 at the next edge.
  - s_flush_Q has priority over div_start in the same cycle: the counter ends at 0.
  - No wrap: decrement is never applied at 0.
- ACT=0: no register updates except the asynchronous reset; stall outputs and div_start are 0.
- Reset mid-divide: the counter is cleared immediately; there is no residual busy.

Decomposition:
- Package issue_hazard_pkg: REG_W=5, class/lane enums, and the function regmatch(idx, use, rd) that applies the x0 exclusion.
- Optional sub-module div_occupancy_t: counter plus div_rd register with start/kill/busy.

Test Plan:
- Lane1 older `add x5`, lane2 `sub x6,x5,x1` -> cycle0: id2_stall=1, id1_stall=0, if_stall=1. Cycle1: issued=01, lane2 issues, if_stall=0, mask then 00.
- Lane1 `lw x7` issues; next pair lane1 reads x7 -> id1_stall=1 and id2_stall=1 for exactly 1 cycle. The same with s_ex1_clear_Q=1 on the load's EX cycle -> no stall.
- With DIV_CYCLES=8, `div x9` issues -> div_busy high for 7 cycles. A reader of x9 stalls for all 7. A second div stalls for all 7. An independent `add x3` never stalls.
- id_lane2_first=1, lane2 `lw x4`, lane1 reads x4 -> lane1 (younger) stalls 1 cycle; s_id2_older_D=1.
- div issued, then s_flush_Q=1 two cycles later -> div_busy=0 from the next cycle; a div_rd reader does not stall.
- RST driven low mid-divide with counter=5 -> div_busy, stalls and mask go to 0 immediately; after release, reads of x0 never stall.
